// File: rtl/psum_collector_pkg.sv
// Shared types and constants for the partial-sum collector.
// Contents: layer-mode enum, psum / ofmap bus payloads, per-mode output
// counts, FSM state enum, and small helpers for mode decode and ReLU.
package psum_collector_pkg;

  localparam int unsigned PSUM_W = 12;  // psum width, signed fixed point (12,5)
  localparam int unsigned N_FILT = 4;   // filters per column
  localparam int unsigned FILT_W = 2;   // filter index width
  localparam int unsigned N_LANE = 4;   // psums per ofmap word
  localparam int unsigned LANE_W = 2;   // lane pointer width
  localparam int unsigned CNT_W  = 6;   // per-filter output counter width

  // Outputs per filter for one layer pass
  localparam int unsigned L1_OFMAP_SIZE = 16;
  localparam int unsigned L2_OFMAP_SIZE = 20;
  localparam int unsigned L3_OFMAP_SIZE = 6;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } op_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef logic [N_LANE-1:0][PSUM_W-1:0] pack_data_t;

  typedef struct packed {
    logic              valid;
    logic [PSUM_W-1:0] psum;
    logic [FILT_W-1:0] filter_idx;
  } psum_packet_t;

  typedef struct packed {
    logic              valid;
    logic [FILT_W-1:0] filter_idx;
    pack_data_t        data;
  } ofmap_packet_t;

  // Number of outputs each filter produces in the given mode
  function automatic logic [CNT_W-1:0] mode_ofmap_max(input op_mode_e m);
    case (m)
      MODE1, MODE2: return CNT_W'(L1_OFMAP_SIZE);
      MODE3:        return CNT_W'(L2_OFMAP_SIZE);
      MODE4:        return CNT_W'(L3_OFMAP_SIZE);
      default:      return CNT_W'(L1_OFMAP_SIZE);
    endcase
  endfunction

  // Negative psums clamp to zero
  function automatic logic [PSUM_W-1:0] relu(input logic [PSUM_W-1:0] p);
    return p[PSUM_W-1] ? '0 : p;
  endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Collector-side bus bundle.
//   mode_in/change_mode : layer mode load
//   conv_continue       : start/restart a layer pass
//   psum_in/psum_ack_out: psum stream from the top PE of the column
//   ofmap_out/ofmap_ready: packed output words, valid/ready handshake
//   layer_done/error    : pass status
// slave = collector view, master = driver view.
interface psum_collector_if;
  import psum_collector_pkg::*;

  op_mode_e      mode_in;
  logic          change_mode;
  logic          conv_continue;
  psum_packet_t  psum_in;
  logic          psum_ack_out;
  ofmap_packet_t ofmap_out;
  logic          ofmap_ready;
  logic          layer_done;
  logic          error;

  modport slave (
    input  mode_in, change_mode, conv_continue, psum_in, ofmap_ready,
    output psum_ack_out, ofmap_out, layer_done, error
  );

  modport master (
    output mode_in, change_mode, conv_continue, psum_in, ofmap_ready,
    input  psum_ack_out, ofmap_out, layer_done, error
  );

endinterface

// File: rtl/psum_collector_rr_arbiter4.sv
// 4-request round-robin arbiter.
//   clk, rst      : clock, async active-low reset
//   req           : request vector
//   advance       : the current grant is consumed this cycle
//   gnt_idx_c     : granted index (combinational)
//   gnt_valid_c   : some request is granted (combinational)
// prio_q holds the index searched first; after a grant it moves to the
// slot just after the winner, so the search always starts after the
// last granted requester.
module rr_arbiter4
  import psum_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_FILT-1:0] req,
  input  logic              advance,
  output logic [FILT_W-1:0] gnt_idx_c,
  output logic              gnt_valid_c
);

  logic [FILT_W-1:0] prio_q;
  logic [FILT_W-1:0] cand_c;

  // Scan from the farthest offset down so the nearest requester wins
  always_comb begin
    gnt_idx_c   = '0;
    gnt_valid_c = 1'b0;
    cand_c      = '0;
    for (int k = N_FILT - 1; k >= 0; k--) begin
      cand_c = prio_q + FILT_W'(k);
      if (req[cand_c]) begin
        gnt_idx_c   = cand_c;
        gnt_valid_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= '0;
    end else if (advance && gnt_valid_c) begin
      prio_q <= gnt_idx_c + FILT_W'(1);
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Partial-sum collector: packs ReLU'd psums from one PE column into
// 4-lane words per filter and streams them out through a single output
// register, tracking per-filter output counts for the current layer.
//   clk  : clock, rising edge
//   rst  : async active-low reset
//   bus  : psum_collector_if.slave (mode, pass control, psum in, ofmap out,
//          layer_done, error)
module psum_collector
  import psum_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  psum_collector_if.slave   bus
);

  state_e            state_q, state_d;
  op_mode_e          mode_q;
  logic [CNT_W-1:0]  ofmap_max_c;

  pack_data_t        pack_buf_q [N_FILT];
  logic [LANE_W-1:0] ptr_q      [N_FILT];
  logic [CNT_W-1:0]  cnt_q      [N_FILT];
  logic [N_FILT-1:0] pack_full_q;

  ofmap_packet_t     ofmap_q;
  logic              layer_done_q;
  logic              error_q;

  logic [FILT_W-1:0] in_f_c;
  logic [FILT_W-1:0] gnt_idx_c;
  logic              gnt_valid_c;
  logic              load_c;
  logic              ack_c;
  logic              overflow_c;
  logic              all_done_c;
  logic [CNT_W-1:0]  cnt_next_c;
  logic [LANE_W-1:0] ptr_cur_c;
  pack_data_t        out_data_c;

  assign ofmap_max_c = mode_ofmap_max(mode_q);
  assign in_f_c      = bus.psum_in.filter_idx;
  assign ptr_cur_c   = ptr_q[in_f_c];
  assign cnt_next_c  = cnt_q[in_f_c] + CNT_W'(1);
  assign overflow_c  = (cnt_q[in_f_c] == ofmap_max_c);

  // Output register takes a new pack whenever it is empty or being drained
  assign load_c = gnt_valid_c && !bus.conv_continue &&
                  (!ofmap_q.valid || bus.ofmap_ready);

  // A pack moving to the output register this cycle cannot also take data
  assign ack_c = (state_q == ST_COLLECT) && bus.psum_in.valid &&
                 !pack_full_q[in_f_c] &&
                 !(load_c && (gnt_idx_c == in_f_c));

  rr_arbiter4 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (pack_full_q),
    .advance     (load_c),
    .gnt_idx_c   (gnt_idx_c),
    .gnt_valid_c (gnt_valid_c)
  );

  // Every filter has produced its full quota
  always_comb begin
    all_done_c = 1'b1;
    for (int unsigned f = 0; f < N_FILT; f++) begin
      if (cnt_q[f] != ofmap_max_c) all_done_c = 1'b0;
    end
  end

  // Granted pack with lanes past the write pointer zeroed (ptr 0 = all used)
  always_comb begin
    out_data_c = '0;
    for (int unsigned i = 0; i < N_LANE; i++) begin
      if ((ptr_q[gnt_idx_c] == '0) || (LANE_W'(i) < ptr_q[gnt_idx_c])) begin
        out_data_c[i] = pack_buf_q[gnt_idx_c][i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.conv_continue) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT: if (all_done_c) state_d = ST_FLUSH;
        ST_FLUSH:   if ((pack_full_q == '0) && !ofmap_q.valid) state_d = ST_DONE;
        default:    state_d = state_q;
      endcase
    end
  end

  // State, mode, and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE1;
      layer_done_q <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_done_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      if (bus.change_mode && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
        mode_q <= bus.mode_in;
      end
      if (bus.conv_continue) begin
        error_q <= 1'b0;
      end else if (ack_c && overflow_c) begin
        error_q <= 1'b1;
      end
    end
  end

  // Per-filter pack buffers, lane pointers, and output counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_full_q <= '0;
      for (int unsigned f = 0; f < N_FILT; f++) begin
        pack_buf_q[f] <= '0;
        ptr_q[f]      <= '0;
        cnt_q[f]      <= '0;
      end
    end else if (bus.conv_continue) begin
      pack_full_q <= '0;
      for (int unsigned f = 0; f < N_FILT; f++) begin
        ptr_q[f] <= '0;
        cnt_q[f] <= '0;
      end
    end else begin
      if (load_c) begin
        pack_full_q[gnt_idx_c] <= 1'b0;
        ptr_q[gnt_idx_c]       <= '0;
      end
      // Accepts past the quota are acknowledged but dropped
      if (ack_c && !overflow_c) begin
        pack_buf_q[in_f_c][ptr_cur_c] <= relu(bus.psum_in.psum);
        ptr_q[in_f_c]                 <= ptr_cur_c + LANE_W'(1);
        cnt_q[in_f_c]                 <= cnt_next_c;
        if ((ptr_cur_c == LANE_W'(N_LANE - 1)) || (cnt_next_c == ofmap_max_c)) begin
          pack_full_q[in_f_c] <= 1'b1;
        end
      end
    end
  end

  // Single output register; held while valid and not taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ofmap_q <= '0;
    end else if (bus.conv_continue) begin
      ofmap_q <= '0;
    end else if (load_c) begin
      ofmap_q.valid      <= 1'b1;
      ofmap_q.filter_idx <= gnt_idx_c;
      ofmap_q.data       <= out_data_c;
    end else if (ofmap_q.valid && bus.ofmap_ready) begin
      ofmap_q.valid <= 1'b0;
    end
  end

  assign bus.psum_ack_out = ack_c;
  assign bus.ofmap_out    = ofmap_q;
  assign bus.layer_done   = layer_done_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector with an ofmap scoreboard.
module tb_psum_collector;
  import psum_collector_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ofmap_packet_t exp_q[$];

  psum_collector_if bus ();

  psum_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] tb_relu(input logic [11:0] p);
    if (p[11]) return 12'h000;
    return p;
  endfunction

  function automatic ofmap_packet_t mk_word(input logic [1:0] f,
      input logic [11:0] v0, input logic [11:0] v1,
      input logic [11:0] v2, input logic [11:0] v3, input int n);
    ofmap_packet_t w;
    logic [11:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    w.valid      = 1'b1;
    w.filter_idx = f;
    for (int i = 0; i < 4; i++) w.data[i] = (i < n) ? tb_relu(v[i]) : 12'h000;
    return w;
  endfunction

  // Present one psum, wait (bounded) for ack, complete the transfer
  task automatic send(input logic [1:0] f, input logic [11:0] p);
    int n;
    n = 0;
    bus.psum_in = '{valid: 1'b1, psum: p, filter_idx: f};
    @(negedge clk);
    while (bus.psum_ack_out !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("psum_ack", 64'(bus.psum_ack_out), 64'(1'b1));
    @(posedge clk); #1;
    bus.psum_in = '0;
  endtask

  task automatic send_pack(input logic [1:0] f,
      input logic [11:0] v0, input logic [11:0] v1,
      input logic [11:0] v2, input logic [11:0] v3,
      input int n, input bit push);
    logic [11:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    if (push) exp_q.push_back(mk_word(f, v0, v1, v2, v3, n));
    for (int i = 0; i < n; i++) send(f, v[i]);
  endtask

  task automatic pulse_continue();
    bus.conv_continue = 1'b1;
    @(posedge clk); #1;
    bus.conv_continue = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.ofmap_out.valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Scoreboard: every word taken downstream must match the next expected one
  always @(negedge clk) begin
    if (rst && bus.ofmap_out.valid && bus.ofmap_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(bus.ofmap_out), 64'(0));
      end else begin
        chk("ofmap_word", 64'(bus.ofmap_out), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    ofmap_packet_t word_a;
    int n;
    n_cmp = 0;
    n_bad = 0;
    rst               = 1'b1;
    bus.mode_in       = MODE1;
    bus.change_mode   = 1'b0;
    bus.conv_continue = 1'b0;
    bus.psum_in       = '0;
    bus.ofmap_ready   = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_ofmap", 64'(bus.ofmap_out), 64'(0));
    chk("rst_ack", 64'(bus.psum_ack_out), 64'(0));
    chk("rst_layer_done", 64'(bus.layer_done), 64'(1));
    chk("rst_error", 64'(bus.error), 64'(0));
    #9 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_layer_done", 64'(bus.layer_done), 64'(1));

    // Basic pack on filter 0, ReLU and one-cycle latency
    bus.ofmap_ready = 1'b1;
    pulse_continue();
    chk("collect_layer_done", 64'(bus.layer_done), 64'(0));
    send_pack(2'd0, 12'h010, 12'hFF0, 12'h020, 12'h030, 4, 1'b1);
    chk("latency_n", 64'(bus.ofmap_out.valid), 64'(0));
    @(posedge clk); #1;
    chk("latency_n1", 64'(bus.ofmap_out.valid), 64'(1));
    chk("latency_data", 64'(bus.ofmap_out.data), 64'({12'h030, 12'h020, 12'h000, 12'h010}));
    @(posedge clk); #1;

    // Backpressure: second pack pending blocks the next psum for filter 0
    bus.ofmap_ready = 1'b0;
    word_a = mk_word(2'd0, 12'h001, 12'h7FF, 12'h800, 12'h004, 4);
    send_pack(2'd0, 12'h001, 12'h7FF, 12'h800, 12'h004, 4, 1'b1);
    send_pack(2'd0, 12'h005, 12'h006, 12'h007, 12'h008, 4, 1'b1);
    bus.psum_in = '{valid: 1'b1, psum: 12'h009, filter_idx: 2'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("blocked_ack", 64'(bus.psum_ack_out), 64'(0));
      chk("hold_word", 64'(bus.ofmap_out), 64'(word_a));
    end
    @(posedge clk); #1;
    bus.ofmap_ready = 1'b1;
    send_pack(2'd0, 12'h009, 12'h00A, 12'h00B, 12'h00C, 4, 1'b1);
    wait_drain();

    // Round robin: all four filters pending, then a new round from filter 0
    pulse_continue();
    bus.ofmap_ready = 1'b0;
    send_pack(2'd3, 12'h301, 12'h302, 12'h303, 12'h304, 4, 1'b1);
    send_pack(2'd0, 12'h001, 12'h002, 12'hF00, 12'h004, 4, 1'b1);
    send_pack(2'd1, 12'h111, 12'h112, 12'h113, 12'h114, 4, 1'b1);
    send_pack(2'd2, 12'h221, 12'h222, 12'h223, 12'h224, 4, 1'b1);
    send_pack(2'd3, 12'h331, 12'h332, 12'h333, 12'h334, 4, 1'b1);
    bus.ofmap_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid", 64'(bus.ofmap_out.valid), 64'(1));
      @(posedge clk); #1;
    end
    bus.ofmap_ready = 1'b0;
    exp_q.push_back(mk_word(2'd0, 12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4, 4));
    exp_q.push_back(mk_word(2'd2, 12'h2A1, 12'h2A2, 12'h2A3, 12'h2A4, 4));
    send_pack(2'd2, 12'h2A1, 12'h2A2, 12'h2A3, 12'h2A4, 4, 1'b0);
    send_pack(2'd0, 12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4, 4, 1'b0);
    chk("hold_f3_word", 64'(bus.ofmap_out.filter_idx), 64'(3));
    bus.ofmap_ready = 1'b1;
    wait_drain();

    // Reset during a pass with a word held and another pack pending
    bus.ofmap_ready = 1'b0;
    send_pack(2'd1, 12'h123, 12'h124, 12'h125, 12'h126, 4, 1'b0);
    send_pack(2'd2, 12'h223, 12'h224, 12'h225, 12'h226, 4, 1'b0);
    chk("pre_rst_valid", 64'(bus.ofmap_out.valid), 64'(1));
    bus.psum_in = '{valid: 1'b1, psum: 12'h050, filter_idx: 2'd3};
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.ofmap_out.valid), 64'(0));
    chk("mid_rst_layer_done", 64'(bus.layer_done), 64'(1));
    chk("mid_rst_ack", 64'(bus.psum_ack_out), 64'(0));
    bus.psum_in = '0;
    #3 rst = 1'b1;
    @(posedge clk); #1;

    // MODE4 pass: partial final packs are zero padded, then FLUSH -> DONE
    bus.mode_in     = MODE4;
    bus.change_mode = 1'b1;
    @(posedge clk); #1;
    bus.change_mode = 1'b0;
    bus.ofmap_ready = 1'b1;
    pulse_continue();
    for (int f = 0; f < 4; f++) begin
      send_pack(2'(f), 12'(16 * f + 1), 12'hFFF, 12'(16 * f + 3), 12'h7FF, 4, 1'b1);
      send_pack(2'(f), 12'(16 * f + 5), 12'(16 * f + 6), 12'h000, 12'h000,
                int'(L3_OFMAP_SIZE) - 4, 1'b1);
    end
    n = 0;
    @(negedge clk);
    while (!(bus.ofmap_out.valid && bus.ofmap_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("last_word_seen", 64'(bus.ofmap_out.valid), 64'(1));
    @(posedge clk); #1;
    chk("flush_layer_done", 64'(bus.layer_done), 64'(0));
    @(posedge clk); #1;
    chk("done_layer_done", 64'(bus.layer_done), 64'(1));
    chk("done_queue", 64'(exp_q.size()), 64'(0));

    // Overrun after the quota; mode change ignored mid-pass
    pulse_continue();
    chk("restart_layer_done", 64'(bus.layer_done), 64'(0));
    bus.mode_in     = MODE1;
    bus.change_mode = 1'b1;
    @(posedge clk); #1;
    bus.change_mode = 1'b0;
    send_pack(2'd0, 12'h011, 12'h012, 12'h013, 12'h014, 4, 1'b1);
    send_pack(2'd0, 12'h015, 12'h016, 12'h000, 12'h000, int'(L3_OFMAP_SIZE) - 4, 1'b1);
    send(2'd0, 12'h055);
    chk("overrun_error", 64'(bus.error), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("overrun_no_word", 64'(bus.ofmap_out.valid), 64'(0));
    chk("overrun_queue", 64'(exp_q.size()), 64'(0));
    pulse_continue();
    chk("error_cleared", 64'(bus.error), 64'(0));
    chk("error_clear_collect", 64'(bus.layer_done), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rising edge only.
REQ-002 SHALL have ports: rst  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: mode_in  in  OP_MODE  layer mode; sampled when change_mode=1.
REQ-004 SHALL have ports: change_mode  in  1  load mode_in.
REQ-005 SHALL have ports: conv_continue  in  1  start or restart a layer pass.
REQ-006 SHALL have ports: psum_in  in  PSUM_PACKET  {valid, psum[11:0] signed (12,5), filter_idx[1:0]} from the top PE of the column.
REQ-007 SHALL have ports: psum_ack_out  out  1  psum_in accepted this cycle; returned as the PE's psum_ack_in.
REQ-008 SHALL have ports: ofmap_out  out  OFMAP_PACKET  {valid, filter_idx[1:0], data[3:0][11:0]}.
REQ-009 SHALL have ports: ofmap_ready  in  1  downstream takes ofmap_out when valid && ready.
REQ-010 SHALL have ports: layer_done  out  1  all outputs of the pass have been emitted.
REQ-011 SHALL have ports: error  out  1  sticky overrun flag.

Function
REQ-012 SHALL implement FSM IDLE->COLLECT on conv_continue; COLLECT->FLUSH when all 4 filter counters reach ofmap_max; FLUSH->DONE when no pack is pending and the output register is empty; DONE->COLLECT on conv_continue.
REQ-013 SHALL set ofmap_max per mode: MODE1/MODE2 = `L1_OFMAP_SIZE; MODE3 = `L2_OFMAP_SIZE; MODE4 = `L3_OFMAP_SIZE.
REQ-014 SHALL apply change_mode only in IDLE or DONE; change_mode in COLLECT or FLUSH is ignored.
REQ-015 SHALL keep, per filter f, a 4-lane pack buffer, a 2-bit lane pointer, a 6-bit output counter cnt[f] and a pack_full[f] flag.
REQ-016 SHALL drive psum_ack_out = 1 iff state==COLLECT, psum_in.valid, !pack_full[psum_in.filter_idx], and that filter's pack is not moving to the output register in the same cycle; the signal is combinational.
REQ-017 SHALL, on accept: write lane[ptr] = ReLU(psum), where a negative value (bit 11 set) becomes 0 and a positive value passes unchanged; then increment ptr and cnt[f], and set pack_full[f] when ptr wraps 3->0 or cnt[f]+1 == ofmap_max.
REQ-018 SHALL, on an accept with cnt[f] == ofmap_max, still ack, drop the data, and set error; error stays set until reset or conv_continue.
REQ-019 SHALL use a single output register; on a cycle where it is empty or being taken, it loads the pending full pack selected round-robin (start after the last granted filter), zero-fills unused lanes, and clears that pack_full and ptr.
REQ-020 SHALL have latency: the 4th accept at cycle N makes ofmap_out.valid=1 at N+1 if no other pack is pending.
REQ-021 SHALL hold ofmap_out stable while valid && !ofmap_ready.
REQ-022 SHALL assert layer_done=1 in DONE and IDLE, and 0 in COLLECT and FLUSH.
REQ-023 SHALL, on conv_continue in any state, clear counters, pointers, pack_full, and error, discard pending packs and the output register, and enter COLLECT.

Reset
REQ-024 SHALL reset to: state IDLE, mode MODE1, ofmap_out all zero (valid=0), psum_ack_out 0, layer_done 1, error 0, all buffers, counters, and pointers 0, round-robin pointer 0.
REQ-025 SHALL, on a reset asserted mid-pass, abort immediately with no output emitted.

Structure
REQ-026 SHALL place OFMAP_PACKET, OP_MODE, PSUM_PACKET, and the `L*_OFMAP_SIZE constants in the shared package or defines file.
REQ-027 SHALL use one sub-module, rr_arbiter4, a 4-request round-robin grant with a registered last-grant pointer.

Verification
REQ-028 SHALL cover MODE1 with psums 0x010, 0xFF0, 0x020, 0x030 on filter 0 -> one ofmap word, filter 0, data {0x030, 0x020, 0x000, 0x010}, valid at cycle after the 4th ack.
REQ-029 SHALL cover holding ofmap_ready=0 while filter 0 fills a second pack -> the 5th psum for filter 0 gets ack=0 until the first word is taken; ofmap_out stays unchanged meanwhile.
REQ-030 SHALL cover all 4 filters completing packs in the same cycle with ofmap_ready=1 -> words emitted in order 0, 1, 2, 3 on consecutive cycles; a following round starts at filter 0 if filter 3 was last granted.
REQ-031 SHALL cover a MODE4 pass with `L3_OFMAP_SIZE not a multiple of 4 -> the final pack per filter is zero-padded, FLUSH->DONE, and layer_done rises 1 cycle after the last word is taken.
REQ-032 SHALL cover an extra psum after cnt[f]==ofmap_max -> the psum is acked, no word is emitted, and error=1; conv_continue clears error to 0.
REQ-033 SHALL cover reset asserted during COLLECT with a pack pending -> ofmap_out.valid=0 immediately and layer_done=1.
